// File: rtl/shim_queue_if.sv
// Block-stream bundle between the PCS-side writer, the shim queue and the release controller.
// The master drives the incoming blocks and pop requests; the slave (the queue) drives the views and status.
interface shim_queue_if #(
    parameter int ADDR_W = 8
);
    logic [1:0]      rx_c;
    logic [63:0]     rx_d;
    logic            shimq_read;
    logic [1:0]      shim_inc;
    logic [63:0]     shim_ind;
    logic [1:0]      shim_outc;
    logic [63:0]     shim_outd;
    logic [ADDR_W:0] shimq_pkts;
    logic            shim_drop;
    logic            shim_trunc;

    modport master (
        output rx_c, rx_d, shimq_read,
        input  shim_inc, shim_ind, shim_outc, shim_outd, shimq_pkts, shim_drop, shim_trunc
    );

    modport slave (
        input  rx_c, rx_d, shimq_read,
        output shim_inc, shim_ind, shim_outc, shim_outd, shimq_pkts, shim_drop, shim_trunc
    );
endinterface

// File: rtl/shim_queue.sv
// Packet-aware 66-bit block buffer: stores whole packets only and drains committed blocks on request.
// Space for a full maximum-length packet is reserved at the start block, so writes never hit full mid-packet.
module shim_queue #(
    parameter int ADDR_W         = 8,
    parameter int MAX_PKT_BLOCKS = 200
) (
    input  logic        clk,
    input  logic        rst_n,
    shim_queue_if.slave bus
);
    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [1:0]      ST_IDLE   = 2'd0;
    localparam logic [1:0]      ST_PKT    = 2'd1;
    localparam logic [1:0]      ST_SKIP   = 2'd2;
    localparam logic [1:0]      SYNC_CTL  = 2'b01;
    localparam logic [63:0]     IDLE_D    = 64'h1E;
    localparam logic [63:0]     TERM_D    = 64'h87;
    localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] DEPTH_P   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] MAX_BLK   = MAX_PKT_BLOCKS[ADDR_W:0];

    function automatic logic is_start(input logic [1:0] c, input logic [7:0] t);
        return (c == SYNC_CTL) && ((t == 8'h78) || (t == 8'h33) || (t == 8'h66));
    endfunction

    function automatic logic is_term(input logic [1:0] c, input logic [7:0] t);
        return (c == SYNC_CTL) && (t > 8'h86);
    endfunction

    logic [65:0]     mem_q [DEPTH];
    logic [1:0]      state_q, state_d;
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, commit_ptr_q, commit_ptr_d;
    logic [ADDR_W:0] len_q, len_d, pkts_q, pkts_d, free_s;
    logic            drop_q, drop_d, trunc_q, trunc_d;
    logic [1:0]      inc_q, inc_d, outc_q, outc_d;
    logic [63:0]     ind_q, ind_d, outd_q, outd_d;
    logic            in_start_s, in_term_s, wr_en_s, commit_s, pop_s, pop_term_s;
    logic [1:0]      wr_c_s;
    logic [63:0]     wr_dat_s;
    logic [65:0]     head_s;

    assign in_start_s = is_start(bus.rx_c, bus.rx_d[7:0]);
    assign in_term_s  = is_term(bus.rx_c, bus.rx_d[7:0]);
    assign free_s     = DEPTH_P - (wr_ptr_q - rd_ptr_q);
    assign head_s     = mem_q[rd_ptr_q[ADDR_W-1:0]];

    // Write-side packet FSM: admission, length limit, truncation and commit.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        wr_en_s      = 1'b0;
        commit_s     = 1'b0;
        wr_c_s       = bus.rx_c;
        wr_dat_s     = bus.rx_d;
        drop_d       = 1'b0;
        trunc_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_start_s) begin
                    if (free_s >= MAX_BLK) begin
                        wr_en_s = 1'b1;
                        len_d   = PTR_ONE;
                        state_d = ST_PKT;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = ST_SKIP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PKT: begin
                wr_en_s = 1'b1;
                if (in_term_s) begin
                    commit_s = 1'b1;
                    len_d    = {(ADDR_W+1){1'b0}};
                    state_d  = ST_IDLE;
                end else if (len_q == (MAX_BLK - PTR_ONE)) begin
                    // The block that would overflow the limit is replaced by a terminate.
                    wr_c_s   = SYNC_CTL;
                    wr_dat_s = TERM_D;
                    commit_s = 1'b1;
                    trunc_d  = 1'b1;
                    len_d    = {(ADDR_W+1){1'b0}};
                    state_d  = ST_SKIP;
                end else begin
                    len_d = len_q + PTR_ONE;
                end
            end
            ST_SKIP: begin
                if (in_term_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SKIP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                len_d   = {(ADDR_W+1){1'b0}};
            end
        endcase
    end

    // Pointer, packet-count and output-view next-state logic.
    always_comb begin
        wr_ptr_d     = wr_en_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        commit_ptr_d = commit_s ? (wr_ptr_q + PTR_ONE) : commit_ptr_q;
        inc_d        = wr_en_s ? wr_c_s : SYNC_CTL;
        ind_d        = wr_en_s ? wr_dat_s : IDLE_D;
        pop_s        = bus.shimq_read && (rd_ptr_q != commit_ptr_q);
        pop_term_s   = pop_s && is_term(head_s[65:64], head_s[7:0]);
        rd_ptr_d     = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        outc_d       = pop_s ? head_s[65:64] : SYNC_CTL;
        outd_d       = pop_s ? head_s[63:0] : IDLE_D;
        case ({commit_s, pop_term_s})
            2'b10:   pkts_d = pkts_q + PTR_ONE;
            2'b01:   pkts_d = pkts_q - PTR_ONE;
            default: pkts_d = pkts_q;
        endcase
    end

    // Block storage; contents are invalidated by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= {wr_c_s, wr_dat_s};
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= {(ADDR_W+1){1'b0}};
            rd_ptr_q     <= {(ADDR_W+1){1'b0}};
            commit_ptr_q <= {(ADDR_W+1){1'b0}};
            len_q        <= {(ADDR_W+1){1'b0}};
            pkts_q       <= {(ADDR_W+1){1'b0}};
            drop_q       <= 1'b0;
            trunc_q      <= 1'b0;
            inc_q        <= SYNC_CTL;
            ind_q        <= IDLE_D;
            outc_q       <= SYNC_CTL;
            outd_q       <= IDLE_D;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            len_q        <= len_d;
            pkts_q       <= pkts_d;
            drop_q       <= drop_d;
            trunc_q      <= trunc_d;
            inc_q        <= inc_d;
            ind_q        <= ind_d;
            outc_q       <= outc_d;
            outd_q       <= outd_d;
        end
    end

    assign bus.shim_inc   = inc_q;
    assign bus.shim_ind   = ind_q;
    assign bus.shim_outc  = outc_q;
    assign bus.shim_outd  = outd_q;
    assign bus.shimq_pkts = pkts_q;
    assign bus.shim_drop  = drop_q;
    assign bus.shim_trunc = trunc_q;
endmodule
